// File: rtl/asip_datapath.sv
// asip_datapath: register file, buses, ALU, flags and memory port of the
// MAX/MIN/AVG ASIP. All control comes from ControlUnit as per-cycle strobes;
// this block only decodes them into register updates and bus steering.
module asip_datapath #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Load_MAX_R,
    input  logic              Load_MIN_R,
    input  logic              Load_R0,
    input  logic              Load_COUNT_R,
    input  logic              Load_SUM_R,
    input  logic              Load_PC,
    input  logic              Load_IR,
    input  logic              Load_TEMP_R,
    input  logic              Load_ADDRESS_R,
    input  logic              Load_TEMP_ADD_R,
    input  logic              Load_OPERAND_A_R,
    input  logic              Load_OPERAND_B_R,
    input  logic              INC_PC,
    input  logic              INC_TEMP_AR,
    input  logic              Dec_COUNT,
    input  logic [2:0]        Select_BUS_1_MUX,
    input  logic [1:0]        Select_BUS_2_MUX,
    input  logic              Select_MEMORY_DEMUX,
    input  logic              Load_SIGN_DFF,
    input  logic              Load_ZERO_DFF,
    input  logic [1:0]        Select_ALU_OP,
    input  logic              Write_MEMORY,
    input  logic [DATA_W-1:0] Mem_RDATA,
    output logic [DATA_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Mem_WDATA,
    output logic              Mem_WE,
    output logic [DATA_W-1:0] IR_value,
    output logic [DATA_W-1:0] PC_value,
    output logic              Sign_value,
    output logic              Count_zero
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] max_r, min_r, r0, count_r, sum_r, pc, ir, temp_r;
    logic [DATA_W-1:0] address_r, temp_add_r, operand_a_r, operand_b_r;
    logic              sign_dff, zero_dff;

    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] bus_1;
    logic [DATA_W-1:0] bus_2;
    logic [DATA_W-1:0] alu_y;
    logic              borrow;

    // Read data only reaches the data bus when the demux steers it there;
    // with demux=0 it is reserved for the instruction register.
    assign mem_data = Select_MEMORY_DEMUX ? Mem_RDATA : '0;

    // Data bus source mux.
    always_comb begin
        bus_1 = '0;
        case (Select_BUS_1_MUX)
            3'd0: bus_1 = mem_data;
            3'd1: bus_1 = r0;
            3'd2: bus_1 = max_r;
            3'd3: bus_1 = min_r;
            3'd4: bus_1 = sum_r;
            3'd5: bus_1 = count_r;
            3'd6: bus_1 = temp_r;
            3'd7: bus_1 = alu_y;
            default: bus_1 = '0;
        endcase
    end

    // Address bus source mux; code 3 parks the address at zero.
    always_comb begin
        bus_2 = '0;
        case (Select_BUS_2_MUX)
            2'd0: bus_2 = pc;
            2'd1: bus_2 = address_r;
            2'd2: bus_2 = temp_add_r;
            default: bus_2 = '0;
        endcase
    end

    // ALU: add/sub wrap to DATA_W; shift-right is used to halve a sum for AVG.
    always_comb begin
        alu_y = '0;
        case (Select_ALU_OP)
            2'd0: alu_y = operand_a_r + operand_b_r;
            2'd1: alu_y = operand_a_r - operand_b_r;
            2'd2: alu_y = operand_a_r;
            default: alu_y = operand_a_r >> 1;
        endcase
    end

    // Borrow is the unsigned compare, valid whatever op is selected.
    assign borrow = (operand_a_r < operand_b_r);

    // Plain load-or-hold data registers fed from the data bus.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            max_r       <= '0;
            min_r       <= '0;
            r0          <= '0;
            sum_r       <= '0;
            temp_r      <= '0;
            address_r   <= '0;
            operand_a_r <= '0;
            operand_b_r <= '0;
        end else begin
            if (Load_MAX_R)       max_r       <= bus_1;
            if (Load_MIN_R)       min_r       <= bus_1;
            if (Load_R0)          r0          <= bus_1;
            if (Load_SUM_R)       sum_r       <= bus_1;
            if (Load_TEMP_R)      temp_r      <= bus_1;
            if (Load_ADDRESS_R)   address_r   <= bus_1;
            if (Load_OPERAND_A_R) operand_a_r <= bus_1;
            if (Load_OPERAND_B_R) operand_b_r <= bus_1;
        end
    end

    // Counting registers: a load always wins over the same-cycle count step.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc         <= '0;
            count_r    <= '0;
            temp_add_r <= '0;
        end else begin
            if (Load_PC)              pc         <= bus_1;
            else if (INC_PC)          pc         <= pc + ONE;
            if (Load_COUNT_R)         count_r    <= bus_1;
            else if (Dec_COUNT)       count_r    <= count_r - ONE;
            if (Load_TEMP_ADD_R)      temp_add_r <= bus_1;
            else if (INC_TEMP_AR)     temp_add_r <= temp_add_r + ONE;
        end
    end

    // IR fetches straight from memory, bypassing the data bus, only when the
    // demux is not steering read data onto the bus.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ir <= '0;
        end else if (Load_IR && !Select_MEMORY_DEMUX) begin
            ir <= Mem_RDATA;
        end
    end

    // Flag flops; the zero flag sees COUNT_R as it was before this edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sign_dff <= 1'b0;
            zero_dff <= 1'b0;
        end else begin
            if (Load_SIGN_DFF) sign_dff <= borrow;
            if (Load_ZERO_DFF) zero_dff <= (count_r == '0);
        end
    end

    assign Mem_ADDR   = bus_2;
    assign Mem_WDATA  = bus_1;
    assign Mem_WE     = Write_MEMORY & ~RESET;
    assign IR_value   = ir;
    assign PC_value   = pc;
    assign Sign_value = sign_dff;
    assign Count_zero = zero_dff;

endmodule

// File: doc/asip_datapath.md
Name: asip_datapath

Overview:
- Datapath of the MAX/MIN/AVG ASIP; it is the consumer end of the ControlUnit control-word interface.
- It takes every load, increment, select, ALU-op and write strobe from ControlUnit.
- It returns IR_value, PC_value, Sign_value and Count_zero to ControlUnit.
- It owns all architectural registers, the two internal buses, the ALU, the flag flops and the external memory port.

Parameters:
- DATA_W, 8, width of all data/address registers, buses and memory words.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Load_MAX_R, Load_MIN_R, Load_R0, Load_COUNT_R, Load_SUM_R, Load_PC, Load_IR, Load_TEMP_R, Load_ADDRESS_R, Load_TEMP_ADD_R, Load_OPERAND_A_R, Load_OPERAND_B_R  in  1 each  register load strobes.
- INC_PC, INC_TEMP_AR, Dec_COUNT  in  1 each  counter strobes.
- Select_BUS_1_MUX  in  3  data-bus source select.
- Select_BUS_2_MUX  in  2  address-bus source select.
- Select_MEMORY_DEMUX  in  1  memory read-data steering.
- Load_SIGN_DFF, Load_ZERO_DFF  in  1 each  flag capture strobes.
- Select_ALU_OP  in  2  ALU operation.
- Write_MEMORY  in  1  memory write strobe.
- Mem_RDATA  in  DATA_W  memory read data, combinational w.r.t. Mem_ADDR.
- Mem_ADDR  out  DATA_W  memory address (= BUS_2).
- Mem_WDATA  out  DATA_W  memory write data (= BUS_1).
- Mem_WE  out  1  memory write enable.
- IR_value  out  DATA_W  instruction register.
- PC_value  out  DATA_W  program counter.
- Sign_value  out  1  SIGN_DFF output.
- Count_zero  out  1  ZERO_DFF output.

Behaviour:
- Reset:
  - RESET high asynchronously clears every register and both flag flops to 0, so IR_value=0, PC_value=0, Sign_value=0 and Count_zero=0.
  - Mem_WE is forced to 0 while RESET is high.
- MEMDATA: equals Mem_RDATA when Select_MEMORY_DEMUX=1, otherwise 0.
- BUS_1 (combinational): 0 MEMDATA, 1 R0, 2 MAX_R, 3 MIN_R, 4 SUM_R, 5 COUNT_R, 6 TEMP_R, 7 ALU_Y.
- BUS_2 (combinational): 0 PC, 1 ADDRESS_R, 2 TEMP_ADD_R, 3 zero. Mem_ADDR = BUS_2.
- IR: loads Mem_RDATA directly when Load_IR=1 and Select_MEMORY_DEMUX=0. Load_IR with demux=1 is ignored; IR holds.
- Other register loads: all registers except IR load BUS_1 on the rising edge when their strobe is 1; otherwise they hold.
- Priority on simultaneous strobes:
  - Load_PC beats INC_PC.
  - Load_COUNT_R beats Dec_COUNT.
  - Load_TEMP_ADD_R beats INC_TEMP_AR.
- Counter wrap:
  - INC_PC and INC_TEMP_AR are +1 modulo 2^DATA_W, so 255 wraps to 0.
  - Dec_COUNT is -1 modulo 2^DATA_W, so 0 wraps to 255.
- ALU (combinational, A=OPERAND_A_R, B=OPERAND_B_R):
  - 00: A+B, truncated to DATA_W.
  - 01: A-B, truncated.
  - 10: pass A.
  - 11: A>>1 (logical).
  - BORROW = 1 when A<B unsigned, independent of the selected op.
- SIGN_DFF: captures BORROW on a clock edge with Load_SIGN_DFF=1.
- ZERO_DFF: captures (COUNT_R==0) on a clock edge with Load_ZERO_DFF=1. The value used is the pre-edge COUNT_R, so a same-cycle Dec_COUNT or Load_COUNT_R is not seen until the next capture.
- Memory write: Mem_WE = Write_MEMORY & ~RESET; Mem_WDATA = BUS_1. Memory samples these on the same CLK edge.
- Latency:
  - All register updates are visible one cycle after the strobe.
  - Bus, ALU and memory-address paths are zero-latency combinational.
- Reset mid-operation: registers clear immediately, without waiting for a clock edge. After RESET falls, the first rising edge obeys the strobes.

Test Plan:
- Reset: drive strobes random, assert RESET mid-cycle -> all outputs 0 immediately; Mem_WE=0 while RESET high.
- Fetch: PC=0x00, Mem[0x00]=0xA5, Select_BUS_2_MUX=0, demux=0, Load_IR=1 and INC_PC=1 for one cycle -> IR_value=0xA5, PC_value=0x01. Repeat with PC=0xFF -> PC_value=0x00.
- Compare: A=0x10, B=0x20, Load_SIGN_DFF=1 -> Sign_value=1. Then A=0x20, B=0x10 -> Sign_value=0. Then A=B=0x33 -> Sign_value=0.
- Count:
  - Load COUNT_R=0x01 via BUS_1 from R0.
  - Dec_COUNT=1 -> COUNT_R=0x00.
  - Next cycle Load_ZERO_DFF=1 -> Count_zero=1.
  - Dec_COUNT again -> COUNT_R=0xFF.
  - Load_COUNT_R and Dec_COUNT together, BUS_1=0x07 -> COUNT_R=0x07.
- Average: A=0xC8, B=0x64, op=00 -> ALU_Y=0x2C, Load_SUM_R=1 with BUS_1=7 -> SUM_R=0x2C. Then op=11 with A=0x2C -> ALU_Y=0x16.
- Memory write: TEMP_ADD_R=0x40, Select_BUS_2_MUX=2, Select_BUS_1_MUX=2, MAX_R=0x9E, Write_MEMORY=1 -> Mem_ADDR=0x40, Mem_WDATA=0x9E, Mem_WE=1. Then INC_TEMP_AR -> Mem_ADDR=0x41.
